// File: rtl/counter_modulo_chain.sv
// counter_modulo_chain
//   Cascade of D modulo-M digit counters on one clock. Digit 0 steps on
//   i_enable. Each higher digit steps when i_enable is high and every
//   lower digit is at its terminal value. Digits are packed little-endian
//   into o_q.
//
//   Build option: define COUNTER_UPDOWN_EN to add the i_dir port and down
//   counting. With the macro undefined the chain counts up only, and the
//   down-count logic is not built.
//
// Parameters
//   M  modulus of every digit (2..2^16)
//   D  number of digits (1..16)
//   N  width of one digit field, ceil(log2(M))
//
// Ports
//   i_clk         rising-edge clock
//   i_aclr        synchronous active-high clear, highest priority
//   i_enable      count request for digit 0
//   i_load        synchronous parallel load, beats i_enable
//   i_load_val    load data; field i is i_load_val[i*N +: N], clamped to M-1
//   i_dir         0 = up, 1 = down (only with COUNTER_UPDOWN_EN)
//   o_q           digit values; digit i is o_q[i*N +: N]
//   o_digit_roll  bit i: digit i and all lower digits are at terminal
//   o_carry_out   i_enable & o_digit_roll[D-1]; the whole chain wraps

module counter_modulo_chain #(
  parameter int M = 10,
  parameter int D = 4,
  localparam int N = $clog2(M)
) (
  input  logic           i_clk,
  input  logic           i_aclr,
  input  logic           i_enable,
  input  logic           i_load,
  input  logic [D*N-1:0] i_load_val,
`ifdef COUNTER_UPDOWN_EN
  input  logic           i_dir,
`endif
  output logic [D*N-1:0] o_q,
  output logic [D-1:0]   o_digit_roll,
  output logic           o_carry_out
);

  localparam logic [N-1:0] LP_MAX = N'(M - 1);
  localparam logic [N-1:0] LP_ONE = N'(1);

  logic [N-1:0] r_q    [D];
  logic [N-1:0] w_nxt  [D];
  logic [N-1:0] w_ld   [D];
  logic [N-1:0] w_term;
  logic [D-1:0] w_at_term;
  logic [D-1:0] w_roll;
  logic [D-1:0] w_step;
  logic         w_chain;

  // Terminal value follows i_dir combinationally, so a direction change
  // re-evaluates the roll flags in the same cycle.
  always_comb begin
    w_term = LP_MAX;
`ifdef COUNTER_UPDOWN_EN
    if (i_dir) w_term = '0;
`endif
  end

  // Ripple chain: w_chain is "all digits below i are at terminal".
  // Kept as a block-local running AND so the roll vector never feeds itself.
  always_comb begin
    w_at_term = '0;
    w_roll    = '0;
    w_step    = '0;
    w_chain   = 1'b1;
    for (int i = 0; i < D; i++) begin
      w_at_term[i] = (r_q[i] == w_term);
      w_step[i]    = i_enable & w_chain;
      w_chain      = w_chain & w_at_term[i];
      w_roll[i]    = w_chain;
    end
  end

  // Per-digit step value and clamped load value.
  always_comb begin
    for (int i = 0; i < D; i++) begin
`ifdef COUNTER_UPDOWN_EN
      if (i_dir)
        w_nxt[i] = w_at_term[i] ? LP_MAX : (r_q[i] - LP_ONE);
      else
        w_nxt[i] = w_at_term[i] ? '0 : (r_q[i] + LP_ONE);
`else
      w_nxt[i] = w_at_term[i] ? '0 : (r_q[i] + LP_ONE);
`endif
      w_ld[i] = (i_load_val[i*N +: N] > LP_MAX) ? LP_MAX : i_load_val[i*N +: N];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_aclr) begin
      for (int i = 0; i < D; i++) r_q[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < D; i++) r_q[i] <= w_ld[i];
    end else begin
      for (int i = 0; i < D; i++) begin
        if (w_step[i]) r_q[i] <= w_nxt[i];
      end
    end
  end

  always_comb begin
    o_q = '0;
    for (int i = 0; i < D; i++) o_q[i*N +: N] = r_q[i];
    o_digit_roll = w_roll;
    o_carry_out  = i_enable & w_roll[D-1];
  end

endmodule

// File: doc/counter_modulo_chain.md
# counter_modulo_chain

Parametrised cascade of D modulo-M digit counters sharing one clock, with synchronous load, per-digit ripple-carry flags and a chain carry-out. It generalises the single modulo-k counter to multi-digit BCD, time-of-day and prescaler-chain use on the board designs. Optional up/down counting is compiled in with a macro. Digits are packed little-endian into one output bus.

## Interface
- M, default 10: modulus of every digit; legal range 2..2^16.
- D, default 4: number of cascaded digits; legal range 1..16.
- N (localparam) = ceil(log2(M)): width of one digit field.
- clk  in  1  rising-edge clock.
- aclr  in  1  reset, synchronous, active-high; clears all state on the next clk edge.
- enable  in  1  count request for digit 0 this cycle.
- load  in  1  synchronous parallel load.
- load_val  in  D*N  load data; digit i is load_val[i*N +: N].
- dir  in  1  0 = up, 1 = down; present only when COUNTER_UPDOWN_EN is defined.
- Q  out  D*N  digit values; digit i is Q[i*N +: N], digit 0 least significant.
- digit_roll  out  D  digit_roll[i] = digit i and all lower digits are at their terminal value.
- carry_out  out  1  enable & digit_roll[D-1]; high in the cycle the whole chain wraps.

## Operation
- Per-cycle priority: aclr > load > enable > hold.
- aclr: every digit set to 0.
- load: digit i takes load_val field i. A field value >= M is stored as M-1. enable is ignored in a load cycle.
- Terminal value of a digit: M-1 when counting up, 0 when counting down.
- Digit i steps when enable = 1 and digit_roll[i-1] = 1. Digit 0 steps on enable alone.
- Up step: terminal -> 0, otherwise +1.
- Down step: terminal -> M-1, otherwise -1.
- enable = 0: all digits hold, including digits sitting at terminal. There is no free wrap at M-1.
- digit_roll and carry_out are combinational from Q, dir and enable; they are not registered.
- Digit values outside 0..M-1 are unreachable.
- If M is not a power of two, unused codes never appear on Q.
- A dir change takes effect in the same cycle: terminal values and digit_roll re-evaluate immediately.

## Timing
- Reset values: Q = 0.
- After reset, digit_roll = 0 in up mode, or all ones in down mode.
- After reset, carry_out = enable & digit_roll[D-1].
- Latency: Q reflects an enable, load or aclr on the first rising clk edge where it is sampled.
- All digits update on that same edge; there is no ripple delay in cycles.
- carry_out is asserted in the same cycle as the enable that causes the full wrap. Q shows the wrapped value (all 0 up, all M-1 down) on the next edge.
- aclr mid-count clears on the next edge regardless of load and enable.
- load together with aclr: aclr wins.
- Combinational path: Q -> digit_roll -> next-state, depth O(D). The team accepts this up to D = 16.

## Configuration
- COUNTER_UPDOWN_EN defined: the dir port exists and down counting behaves as above.
- COUNTER_UPDOWN_EN undefined: no dir port and up-only counting. The terminal value is always M-1, and the down-count logic is absent from the netlist.

## Test plan
- Reset, with M=10, D=2: assert aclr for 1 cycle with enable = 1. Required: Q = 0x00 next cycle, digit_roll = 2'b00, carry_out = 0.
- Up ripple, with M=10, D=2: start from 0, hold enable high for 99 cycles. Required: Q = {9,9} and digit_roll = 2'b11; carry_out = 1 in that cycle. One more enable gives Q = {0,0}.
- Hold at terminal: load {0,9} and keep enable low for 5 cycles. Required: Q stays {0,9}, digit_roll[0] = 1, carry_out = 0.
- Load clamp and priority, with M=10, D=2 (4-bit digit fields): load_val = {4'd12, 4'd3} with load = 1 and enable = 1. Required: Q = {9,3}, no increment. Next, load = 1 with aclr = 1; required: Q = 0.
- Down mode (COUNTER_UPDOWN_EN defined), with M=10, D=2: from Q = {1,0}, dir = 1, enable 1 cycle. Required: Q = {0,9}. After 9 more enables, Q = {0,0} and carry_out = 1; the next enable gives {9,9}.
- Non-power-of-two modulus, with M=5, D=3: 125 enables from reset. Required: Q returns to 0, carry_out pulses exactly once, and no digit ever exceeds 4.
